// File: rtl/flex_counter_ud_if.sv
// Control/status bundle for flex_counter_ud. The master drives the controls
// and observes the count; the slave is the counter itself.
interface flex_counter_ud_if #(
  parameter int unsigned NUM_CNT_BITS = 4
) ();

  logic                    clear;
  logic                    load;
  logic [NUM_CNT_BITS-1:0] load_val;
  logic                    count_enable;
  logic                    dir;
  logic                    one_shot;
  logic [NUM_CNT_BITS-1:0] start_val;
  logic [NUM_CNT_BITS-1:0] rollover_val;

  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    rollover_flag;
  logic                    wrap_pulse;
  logic                    done;

  modport master (
    output clear,
    output load,
    output load_val,
    output count_enable,
    output dir,
    output one_shot,
    output start_val,
    output rollover_val,
    input  count_out,
    input  rollover_flag,
    input  wrap_pulse,
    input  done
  );

  modport slave (
    input  clear,
    input  load,
    input  load_val,
    input  count_enable,
    input  dir,
    input  one_shot,
    input  start_val,
    input  rollover_val,
    output count_out,
    output rollover_flag,
    output wrap_pulse,
    output done
  );

endinterface

// File: rtl/flex_counter_ud.sv
// Up/down counter between start_val and rollover_val with wrap or one-shot
// behaviour, synchronous clear/load, registered terminal flag and wrap pulse.
module flex_counter_ud #(
  parameter int unsigned                NUM_CNT_BITS = 4,
  parameter logic [NUM_CNT_BITS-1:0]    RESET_VAL    = '0
) (
  input logic               clk,
  input logic               n_rst,
  flex_counter_ud_if.slave  ctr
);

  localparam logic [NUM_CNT_BITS-1:0] CntOne = NUM_CNT_BITS'(1);

  typedef enum logic [0:0] {
    StCount,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    flag_q, flag_d;
  logic                    pulse_q, pulse_d;

  logic [NUM_CNT_BITS-1:0] term_val;
  logic [NUM_CNT_BITS-1:0] wrap_val;
  logic [NUM_CNT_BITS-1:0] step_val;
  logic                    at_bound;
  logic                    step;

  // Direction selects which bound terminates the run and which one we wrap to.
  assign term_val = ctr.dir ? ctr.start_val    : ctr.rollover_val;
  assign wrap_val = ctr.dir ? ctr.rollover_val : ctr.start_val;
  assign step_val = ctr.dir ? (count_q - CntOne) : (count_q + CntOne);

  // Inclusive compares also catch a count left outside a shrunk range.
  assign at_bound = ctr.dir ? (count_q <= ctr.start_val) : (count_q >= ctr.rollover_val);
  assign step     = ctr.count_enable && (state_q == StCount);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    flag_d  = flag_q;
    pulse_d = 1'b0;

    if (ctr.clear) begin
      state_d = StCount;
      count_d = RESET_VAL;
      flag_d  = 1'b0;
    end else if (ctr.load) begin
      state_d = StCount;
      count_d = ctr.load_val;
      flag_d  = 1'b0;
    end else if (step) begin
      if (!at_bound) begin
        count_d = step_val;
        flag_d  = (step_val == term_val);
      end else if (ctr.one_shot) begin
        // Stopped step: the count stays put and the counter parks until clear/load.
        state_d = StDone;
        flag_d  = (count_q == term_val);
      end else begin
        count_d = wrap_val;
        flag_d  = (wrap_val == term_val);
        pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StCount;
      count_q <= RESET_VAL;
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      flag_q  <= flag_d;
      pulse_q <= pulse_d;
    end
  end

  assign ctr.count_out     = count_q;
  assign ctr.rollover_flag = flag_q;
  assign ctr.wrap_pulse    = pulse_q;
  assign ctr.done          = (state_q == StDone);

  // A wrap pulse only follows a wrap-mode step, which never parks the counter.
  pulse_excludes_done_a : assert property (
    @(posedge clk) disable iff (!n_rst) !(pulse_q && (state_q == StDone))
  );

endmodule

// File: tb/tb_flex_counter_ud.sv
// Self-checking bench for flex_counter_ud: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_flex_counter_ud;

  typedef struct {
    int unsigned cnt;
    bit          flag;
    bit          pulse;
    bit          done;
  } model_t;

  logic   clk;
  logic   n_rst;
  int     n_checks;
  int     n_errors;
  model_t m4;
  model_t m8;

  int unsigned seq1 [7] = '{1, 2, 3, 4, 5, 1, 2};
  int unsigned seq2 [6] = '{5, 4, 3, 2, 6, 5};

  flex_counter_ud_if #(.NUM_CNT_BITS(4)) if4 ();
  flex_counter_ud_if #(.NUM_CNT_BITS(8)) if8 ();

  flex_counter_ud #(.NUM_CNT_BITS(4), .RESET_VAL(4'd0)) u4 (
    .clk   (clk),
    .n_rst (n_rst),
    .ctr   (if4)
  );

  flex_counter_ud #(.NUM_CNT_BITS(8), .RESET_VAL(8'd3)) u8 (
    .clk   (clk),
    .n_rst (n_rst),
    .ctr   (if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic model_t model_reset(input int unsigned v);
    model_t r;
    r.cnt = v; r.flag = 1'b0; r.pulse = 1'b0; r.done = 1'b0;
    return r;
  endfunction

  // One clock of the counter as described by its rules, in plain integers.
  function automatic model_t model_step(input model_t s, input bit clr, input bit ld,
                                        input int unsigned lv, input bit en, input bit dn,
                                        input bit os, input int unsigned lo,
                                        input int unsigned hi, input int unsigned rv);
    model_t      n;
    int unsigned term;
    n = s;
    n.pulse = 1'b0;
    if (clr) return model_reset(rv);
    if (ld) return model_reset(lv);
    if (!en || s.done) return n;
    term = dn ? lo : hi;
    if (!dn && s.cnt < hi)     n.cnt = s.cnt + 1;
    else if (dn && s.cnt > lo) n.cnt = s.cnt - 1;
    else if (os)               n.done = 1'b1;
    else begin
      n.cnt   = dn ? hi : lo;
      n.pulse = 1'b1;
    end
    n.flag = (n.cnt == term);
    return n;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m4 <= model_reset(0);
      m8 <= model_reset(3);
    end else begin
      m4 <= model_step(m4, if4.clear, if4.load, 32'(if4.load_val), if4.count_enable, if4.dir,
                       if4.one_shot, 32'(if4.start_val), 32'(if4.rollover_val), 0);
      m8 <= model_step(m8, if8.clear, if8.load, 32'(if8.load_val), if8.count_enable, if8.dir,
                       if8.one_shot, 32'(if8.start_val), 32'(if8.rollover_val), 3);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("cmp4.count", 32'(if4.count_out),     m4.cnt);
    check("cmp4.flag",  32'(if4.rollover_flag), 32'(m4.flag));
    check("cmp4.pulse", 32'(if4.wrap_pulse),    32'(m4.pulse));
    check("cmp4.done",  32'(if4.done),          32'(m4.done));
    check("cmp8.count", 32'(if8.count_out),     m8.cnt);
    check("cmp8.flag",  32'(if8.rollover_flag), 32'(m8.flag));
    check("cmp8.pulse", 32'(if8.wrap_pulse),    32'(m8.pulse));
    check("cmp8.done",  32'(if8.done),          32'(m8.done));
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_all();
  endtask

  task automatic lit4(input string tag, input int unsigned c, input bit f, input bit p,
                      input bit d);
    check({tag, ".count"}, 32'(if4.count_out),     c);
    check({tag, ".flag"},  32'(if4.rollover_flag), 32'(f));
    check({tag, ".pulse"}, 32'(if4.wrap_pulse),    32'(p));
    check({tag, ".done"},  32'(if4.done),          32'(d));
    check({tag, ".model"}, m4.cnt,                 c);
  endtask

  task automatic lit8(input string tag, input int unsigned c, input bit f, input bit p);
    check({tag, ".count"}, 32'(if8.count_out),     c);
    check({tag, ".flag"},  32'(if8.rollover_flag), 32'(f));
    check({tag, ".pulse"}, 32'(if8.wrap_pulse),    32'(p));
    check({tag, ".model"}, m8.cnt,                 c);
  endtask

  task automatic idle_all();
    if4.clear = 0; if4.load = 0; if4.load_val = '0; if4.count_enable = 0;
    if4.dir = 0; if4.one_shot = 0; if4.start_val = '0; if4.rollover_val = '0;
    if8.clear = 0; if8.load = 0; if8.load_val = '0; if8.count_enable = 0;
    if8.dir = 0; if8.one_shot = 0; if8.start_val = '0; if8.rollover_val = '0;
  endtask

  task automatic rand_drive();
    if4.clear        = ($urandom_range(0, 31) == 0);
    if4.load         = ($urandom_range(0, 15) == 0);
    if4.load_val     = 4'($urandom);
    if4.count_enable = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 15) == 0) if4.dir = ~if4.dir;
    if ($urandom_range(0, 31) == 0) if4.one_shot = 1'($urandom);
    if ($urandom_range(0, 63) == 0) if4.start_val = 4'($urandom);
    if ($urandom_range(0, 63) == 0) if4.rollover_val = 4'($urandom);
    if8.clear        = ($urandom_range(0, 31) == 0);
    if8.load         = ($urandom_range(0, 15) == 0);
    if8.load_val     = 8'($urandom);
    if8.count_enable = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 15) == 0) if8.dir = ~if8.dir;
    if ($urandom_range(0, 31) == 0) if8.one_shot = 1'($urandom);
    if ($urandom_range(0, 63) == 0) begin
      if8.start_val    = 8'($urandom);
      if8.rollover_val = if8.start_val + 8'($urandom_range(0, 12));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_rst    = 1'b0;
    idle_all();
    cycle();
    cycle();
    lit4("reset4", 0, 0, 0, 0);
    lit8("reset8", 3, 0, 0);

    // Up, wrap, start 1, roll 5 from reset value 0.
    n_rst = 1'b1;
    if4.start_val = 4'd1; if4.rollover_val = 4'd5; if4.count_enable = 1;
    for (int i = 0; i < 7; i++) begin
      cycle();
      lit4("up_wrap", seq1[i], (i == 4), (i == 5), 0);
    end

    // Down, wrap, start 2, roll 6 after loading 6.
    if4.dir = 1; if4.start_val = 4'd2; if4.rollover_val = 4'd6;
    if4.load = 1; if4.load_val = 4'd6;
    cycle();
    lit4("down_load", 6, 0, 0, 0);
    if4.load = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      lit4("down_wrap", seq2[i], (i == 3), (i == 4), 0);
    end

    // One-shot up, start 0, roll 3.
    if4.clear = 1; if4.count_enable = 0; if4.dir = 0; if4.one_shot = 1;
    if4.start_val = 4'd0; if4.rollover_val = 4'd3;
    cycle();
    lit4("os_clear", 0, 0, 0, 0);
    if4.clear = 0; if4.count_enable = 1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      lit4("one_shot", (i < 3) ? i + 1 : 3, (i >= 2), 0, (i >= 3));
    end
    if4.one_shot = 0;
    cycle();
    lit4("os_sticky", 3, 1, 0, 1);
    if4.load = 1; if4.load_val = 4'd1;
    cycle();
    lit4("os_load", 1, 0, 0, 0);

    // Priority: clear over load over step.
    if4.load_val = 4'd4; if4.count_enable = 0;
    cycle();
    lit4("pri_pre", 4, 0, 0, 0);
    if4.clear = 1; if4.load = 1; if4.load_val = 4'd9; if4.count_enable = 1;
    cycle();
    lit4("pri_clear", 0, 0, 0, 0);
    if4.clear = 0;
    cycle();
    lit4("pri_load", 9, 0, 0, 0);

    // Out-of-range count wraps on the next step, then an async reset mid-cycle.
    if4.load_val = 4'd12; if4.count_enable = 0;
    cycle();
    lit4("oor_pre", 12, 0, 0, 0);
    if4.load = 0; if4.rollover_val = 4'd7; if4.start_val = 4'd1; if4.count_enable = 1;
    cycle();
    lit4("oor_wrap", 1, 0, 1, 0);
    #2;
    n_rst = 1'b0;
    #1;
    compare_all();
    lit4("async_rst", 0, 0, 0, 0);
    lit8("async_rst8", 3, 0, 0);
    cycle();
    n_rst = 1'b1;
    idle_all();

    // 8-bit full range wrap and a direction flip at 0.
    if8.load = 1; if8.load_val = 8'd253; if8.start_val = 8'd0; if8.rollover_val = 8'd255;
    if8.count_enable = 1;
    cycle();
    lit8("w8_load", 253, 0, 0);
    if8.load = 0;
    cycle();
    lit8("w8_254", 254, 0, 0);
    cycle();
    lit8("w8_255", 255, 1, 0);
    cycle();
    lit8("w8_0", 0, 0, 1);
    if8.dir = 1;
    cycle();
    lit8("w8_flip", 255, 0, 1);
    cycle();
    lit8("w8_254d", 254, 0, 0);

    // Randomized traffic with occasional mid-cycle async resets.
    for (int i = 0; i < 4000; i++) begin
      n_rst = 1'b1;
      rand_drive();
      if ($urandom_range(0, 599) == 0) begin
        #2;
        n_rst = 1'b0;
        #1;
        compare_all();
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
